// File: rtl/pd_hard_reset_tx.sv
// Hard/Cable Reset transmitter: preamble then 4-symbol K-code ordered set to the BMC serializer.
// Latency: write strobe to PHY_ACK is PREAMBLE_SYMS + 4 + 2 cycles with tx_ready held high.
// Backpressure: oSymbol holds while tx_ready is low; a stall of TIMEOUT_CYCLES aborts with oTxFailed.
module pd_hard_reset_tx #(
  parameter int PREAMBLE_SYMS  = 13,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int IFG_CYCLES     = 25
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] iTRANSMIT,
  input  logic       iTRANSMIT_write,
  input  logic       tx_ready,
  output logic [4:0] oSymbol,
  output logic       oSymbol_valid,
  output logic       PHY_ACK,
  output logic       oTxFailed,
  output logic       busy,
  output logic       oIsCable
);

  // Index must cover both the preamble count and the 4 ordered-set positions.
  localparam int IDX_W = (PREAMBLE_SYMS > 4) ? $clog2(PREAMBLE_SYMS) : 2;
  localparam int SW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW    = $clog2(IFG_CYCLES + 1);

  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_SYMS - 1);
  localparam logic [IDX_W-1:0] ORD_LAST  = IDX_W'(3);
  localparam logic [SW-1:0]    STALL_MAX = SW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0]    GAP_LAST  = GW'(IFG_CYCLES - 1);

  localparam logic [4:0] SYM_RST1  = 5'b00111;
  localparam logic [4:0] SYM_RST2  = 5'b11001;
  localparam logic [4:0] SYM_SYNC1 = 5'b11000;
  localparam logic [4:0] SYM_SYNC3 = 5'b00110;
  localparam logic [4:0] SYM_PRE0  = 5'b01010;
  localparam logic [4:0] SYM_PRE1  = 5'b10101;

  localparam logic [2:0] REQ_HARD  = 3'b101;
  localparam logic [2:0] REQ_CABLE = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_ORDSET,
    S_DONE,
    S_FAIL,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [4:0]       sym_q, sym_d;
  logic             valid_q, valid_d;
  logic             ack_q, ack_d;
  logic             failed_q, failed_d;
  logic             cable_q, cable_d;

  logic             xfer;
  logic             stalled;
  logic             unused_transmit_hi;

  // Upper TRANSMIT bits carry no meaning for this stage.
  assign unused_transmit_hi = ^iTRANSMIT[7:3];

  // Ordered-set symbol at position i for the latched request type.
  function automatic logic [4:0] ordset_sym(input logic cable, input logic [1:0] i);
    logic [4:0] s;
    s = SYM_RST1;
    case (i)
      2'd0: s = SYM_RST1;
      2'd1: s = cable ? SYM_SYNC1 : SYM_RST1;
      2'd2: s = SYM_RST1;
      2'd3: s = cable ? SYM_SYNC3 : SYM_RST2;
      default: s = SYM_RST1;
    endcase
    return s;
  endfunction

  // Even preamble positions start with a 0 bit on the wire, odd ones with a 1.
  function automatic logic [4:0] preamble_sym(input logic [IDX_W-1:0] i);
    return i[0] ? SYM_PRE1 : SYM_PRE0;
  endfunction

  assign xfer    = valid_q & tx_ready;
  assign stalled = valid_q & ~tx_ready;

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stall_d  = stall_q;
    gap_d    = gap_q;
    sym_d    = sym_q;
    valid_d  = valid_q;
    ack_d    = 1'b0;
    failed_d = 1'b0;
    cable_d  = cable_q;

    case (state_q)
      S_IDLE: begin
        if (iTRANSMIT_write &&
            (iTRANSMIT[2:0] == REQ_HARD || iTRANSMIT[2:0] == REQ_CABLE)) begin
          cable_d = (iTRANSMIT[2:0] == REQ_CABLE);
          idx_d   = '0;
          stall_d = '0;
          sym_d   = SYM_PRE0;
          valid_d = 1'b1;
          state_d = S_PREAMBLE;
        end
      end

      S_PREAMBLE, S_ORDSET: begin
        if (xfer) begin
          // A transfer always wins over a coincident timeout.
          stall_d = '0;
          if (state_q == S_PREAMBLE) begin
            if (idx_q == PRE_LAST) begin
              idx_d   = '0;
              sym_d   = ordset_sym(cable_q, 2'd0);
              state_d = S_ORDSET;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              sym_d = preamble_sym(idx_q + IDX_W'(1));
            end
          end else begin
            if (idx_q == ORD_LAST) begin
              valid_d = 1'b0;
              sym_d   = '0;
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              sym_d = ordset_sym(cable_q, idx_q[1:0] + 2'd1);
            end
          end
        end else if (stalled) begin
          stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + SW'(1);
          if (stall_d == STALL_MAX) begin
            valid_d = 1'b0;
            sym_d   = '0;
            state_d = S_FAIL;
          end
        end
      end

      S_DONE: begin
        ack_d   = 1'b1;
        gap_d   = '0;
        state_d = S_GAP;
      end

      S_FAIL: begin
        failed_d = 1'b1;
        gap_d    = '0;
        state_d  = S_GAP;
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      stall_q  <= '0;
      gap_q    <= '0;
      sym_q    <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      failed_q <= 1'b0;
      cable_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      stall_q  <= stall_d;
      gap_q    <= gap_d;
      sym_q    <= sym_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      failed_q <= failed_d;
      cable_q  <= cable_d;
    end
  end

  assign oSymbol       = sym_q;
  assign oSymbol_valid = valid_q;
  assign PHY_ACK       = ack_q;
  assign oTxFailed     = failed_q;
  assign busy          = (state_q != S_IDLE);
  assign oIsCable      = cable_q;

endmodule

// File: tb/tb_pd_hard_reset_tx.sv
// Bench for pd_hard_reset_tx: directed requests, expected symbols/events queued, monitor compares.
module tb_pd_hard_reset_tx;

  localparam logic [4:0] RST1  = 5'b00111;
  localparam logic [4:0] RST2  = 5'b11001;
  localparam logic [4:0] SYNC1 = 5'b11000;
  localparam logic [4:0] SYNC3 = 5'b00110;
  localparam logic [4:0] PRE0  = 5'b01010;
  localparam logic [4:0] PRE1  = 5'b10101;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] iTRANSMIT;
  logic       iTRANSMIT_write;
  logic       tx_ready;
  logic [4:0] oSymbol;
  logic       oSymbol_valid;
  logic       PHY_ACK;
  logic       oTxFailed;
  logic       busy;
  logic       oIsCable;

  pd_hard_reset_tx #(
    .PREAMBLE_SYMS (13),
    .TIMEOUT_CYCLES(255),
    .IFG_CYCLES    (25)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .iTRANSMIT      (iTRANSMIT),
    .iTRANSMIT_write(iTRANSMIT_write),
    .tx_ready       (tx_ready),
    .oSymbol        (oSymbol),
    .oSymbol_valid  (oSymbol_valid),
    .PHY_ACK        (PHY_ACK),
    .oTxFailed      (oTxFailed),
    .busy           (busy),
    .oIsCable       (oIsCable)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   at;
    logic cable;
  } ack_t;

  logic [4:0] sym_exp[$];
  ack_t       ack_exp[$];
  int         fail_exp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every presented symbol must match the head of the expected stream.
  always @(negedge CLK) begin
    if (oSymbol_valid === 1'b1) begin
      if (sym_exp.size() == 0) begin
        fail_now("unexpected_symbol", int'(oSymbol), -1);
      end else begin
        chk("symbol", 32'(oSymbol), 32'(sym_exp[0]));
        if (tx_ready) void'(sym_exp.pop_front());
      end
    end
    if (PHY_ACK === 1'b1) begin
      if (ack_exp.size() == 0) begin
        fail_now("unexpected_phy_ack", cyc, -1);
      end else begin
        chk("phy_ack_cycle", 32'(cyc), 32'(ack_exp[0].at));
        chk("is_cable", 32'(oIsCable), 32'(ack_exp[0].cable));
        void'(ack_exp.pop_front());
      end
    end else if (ack_exp.size() > 0 && ack_exp[0].at < cyc) begin
      fail_now("missing_phy_ack", cyc, ack_exp[0].at);
      void'(ack_exp.pop_front());
    end
    if (oTxFailed === 1'b1) begin
      if (fail_exp.size() == 0) begin
        fail_now("unexpected_tx_failed", cyc, -1);
      end else begin
        chk("tx_failed_cycle", 32'(cyc), 32'(fail_exp[0]));
        void'(fail_exp.pop_front());
      end
    end else if (fail_exp.size() > 0 && fail_exp[0] < cyc) begin
      fail_now("missing_tx_failed", cyc, fail_exp[0]);
      void'(fail_exp.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_preamble();
    for (int i = 0; i < 13; i++) sym_exp.push_back((i % 2 == 1) ? PRE1 : PRE0);
  endtask

  task automatic push_frame(input logic cable);
    push_preamble();
    sym_exp.push_back(RST1);
    sym_exp.push_back(cable ? SYNC1 : RST1);
    sym_exp.push_back(RST1);
    sym_exp.push_back(cable ? SYNC3 : RST2);
  endtask

  task automatic strobe(input logic [7:0] v);
    iTRANSMIT       = v;
    iTRANSMIT_write = 1'b1;
    tick(1);
    iTRANSMIT_write = 1'b0;
    iTRANSMIT       = 8'h00;
  endtask

  int k;

  initial begin
    reset           = 1'b1;
    iTRANSMIT       = 8'h00;
    iTRANSMIT_write = 1'b0;
    tx_ready        = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("rst_symbol", 32'(oSymbol), 32'd0);
    chk("rst_valid", 32'(oSymbol_valid), 32'd0);
    chk("rst_ack", 32'(PHY_ACK), 32'd0);
    chk("rst_failed", 32'(oTxFailed), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_is_cable", 32'(oIsCable), 32'd0);
    tick(2);

    // Hard reset, no stall; ACK at strobe+19; request on the GAP->IDLE cycle is dropped.
    k = cyc;
    push_frame(1'b0);
    ack_exp.push_back('{k + 19, 1'b0});
    strobe(8'h05);
    tick(42);
    chk("busy_last_gap", 32'(busy), 32'd1);
    strobe(8'h05);
    chk("idle_after_gap", 32'(busy), 32'd0);
    tick(3);

    // Cable reset with a second strobe while busy, then unsupported codes while idle.
    k = cyc;
    push_frame(1'b1);
    ack_exp.push_back('{k + 19, 1'b1});
    strobe(8'h06);
    tick(3);
    strobe(8'h05);
    tick(45);
    chk("idle_after_cable", 32'(busy), 32'd0);
    strobe(8'h00);
    tick(1);
    chk("ignore_code0", 32'(busy), 32'd0);
    strobe(8'h07);
    tick(1);
    chk("ignore_code7", 32'(busy), 32'd0);
    tick(2);

    // Three-cycle stall mid-preamble shifts the ACK by three cycles.
    k = cyc;
    push_frame(1'b0);
    ack_exp.push_back('{k + 22, 1'b0});
    strobe(8'h05);
    tick(4);
    tx_ready = 1'b0;
    tick(3);
    tx_ready = 1'b1;
    tick(45);
    chk("idle_after_stall", 32'(busy), 32'd0);

    // Permanent stall: abort after 255 stalled cycles, then the gap.
    tx_ready = 1'b0;
    k = cyc;
    push_preamble();
    fail_exp.push_back(k + 257);
    strobe(8'h05);
    tick(255);
    chk("timeout_valid_drop", 32'(oSymbol_valid), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd1);
    tick(25);
    chk("timeout_gap_busy", 32'(busy), 32'd1);
    tick(1);
    chk("timeout_idle", 32'(busy), 32'd0);
    chk("timeout_unsent", 32'(sym_exp.size()), 32'd13);
    sym_exp.delete();
    tx_ready = 1'b1;
    tick(2);

    // Reset during the ordered set abandons the frame without an ACK.
    k = cyc;
    push_preamble();
    sym_exp.push_back(RST1);
    sym_exp.push_back(RST1);
    strobe(8'h05);
    tick(14);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midreset_valid", 32'(oSymbol_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_ack", 32'(PHY_ACK), 32'd0);
    tick(3);

    // A fresh request after the mid-frame reset runs normally.
    k = cyc;
    push_frame(1'b1);
    ack_exp.push_back('{k + 19, 1'b1});
    strobe(8'h06);
    tick(45);
    chk("final_idle", 32'(busy), 32'd0);

    chk("symbols_left", 32'(sym_exp.size()), 32'd0);
    chk("acks_left", 32'(ack_exp.size()), 32'd0);
    chk("fails_left", 32'(fail_exp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pd_hard_reset_tx.md
Name: pd_hard_reset_tx

Overview:
- Downstream PHY-side stage of the protocol-layer hard-reset block; consumes the TRANSMIT register value it writes.
- On a Hard Reset or Cable Reset request, emits a preamble and then the matching 4-symbol K-code ordered set to the BMC serializer, one 5-bit symbol per valid/ready handshake.
- Returns PHY_ACK on success or a failure pulse on serializer stall timeout, then enforces an inter-frame gap before accepting a new request.

Parameters:
- PREAMBLE_SYMS, 13, number of preamble symbols sent before the ordered set (13 symbols = 65 alternating bits).
- TIMEOUT_CYCLES, 255, maximum consecutive stalled cycles (oSymbol_valid=1, tx_ready=0) before abort; minimum 1.
- IFG_CYCLES, 25, cycles held busy after the last symbol before returning to IDLE; minimum 1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- iTRANSMIT  input  8  TRANSMIT register value; bits [2:0] select the request type.
- iTRANSMIT_write  input  1  one-cycle strobe: iTRANSMIT was written this cycle.
- tx_ready  input  1  serializer can accept a symbol this cycle.
- oSymbol  output  5  current 5-bit symbol, LSB transmitted first.
- oSymbol_valid  output  1  oSymbol is valid.
- PHY_ACK  output  1  one-cycle pulse: ordered set fully transferred.
- oTxFailed  output  1  one-cycle pulse: aborted on stall timeout.
- busy  output  1  high in every state except IDLE.
- oIsCable  output  1  latched request type: 1 = cable reset, 0 = hard reset.

Behaviour:
- Reset is synchronous, active-high, and wins over everything, including mid-frame. It forces state IDLE and all counters to 0.
- Output reset values: oSymbol=0, oSymbol_valid=0, PHY_ACK=0, oTxFailed=0, busy=0, oIsCable=0.
- Symbol codes:
  - RST-1 = 5'b00111, RST-2 = 5'b11001.
  - Sync-1 = 5'b11000, Sync-3 = 5'b00110.
  - Preamble symbols alternate, starting with 5'b01010 and then 5'b10101, so the serial bitstream starts with 0 and alternates.
- Ordered sets:
  - Hard reset (iTRANSMIT[2:0]=3'b101): RST-1, RST-1, RST-1, RST-2.
  - Cable reset (iTRANSMIT[2:0]=3'b110): RST-1, Sync-1, RST-1, Sync-3.
- Transfer rule: a symbol transfers on a cycle with oSymbol_valid=1 and tx_ready=1.
  - oSymbol is registered and holds stable while valid=1 and ready=0.
  - The next symbol is presented the cycle after a transfer; no bubbles inside a frame.
- State machine:
  - IDLE: valid=0. On iTRANSMIT_write with [2:0]=101 or 110:
    - latch oIsCable;
    - clear the symbol index and stall counter;
    - go to PREAMBLE, with oSymbol_valid=1 and the first preamble symbol on the next cycle.
    - Any other [2:0] code is ignored; stay in IDLE.
  - PREAMBLE: send PREAMBLE_SYMS symbols. After the last preamble transfer, go to ORDSET with index 0.
  - ORDSET: send 4 symbols. After the 4th transfer:
    - oSymbol_valid=0;
    - pulse PHY_ACK on the next cycle;
    - go to GAP.
  - GAP: count IFG_CYCLES, then go to IDLE. A new request is accepted in the IDLE cycle after GAP.
  - FAIL: entered from PREAMBLE or ORDSET when the stall counter reaches TIMEOUT_CYCLES.
    - Drop oSymbol_valid on entry.
    - Pulse oTxFailed for one cycle, then go to GAP.
- Stall counter:
  - Increments on each cycle with valid=1 and ready=0.
  - Clears on every transfer.
  - Width is $clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.
- Requests while busy=1 are ignored (no queue, no latch). A request arriving in the same cycle as GAP→IDLE is also ignored.
- Simultaneous timeout and transfer in the same cycle: the transfer wins and the counter clears.
- PHY_ACK and oTxFailed are mutually exclusive per request.
- Total latency, write strobe to PHY_ACK with tx_ready held high: PREAMBLE_SYMS + 4 + 2 cycles.

Test Plan:
- Reset, then iTRANSMIT=8'h05 with strobe and tx_ready=1:
  - 13 preamble symbols alternating 01010/10101, then 00111, 00111, 00111, 11001;
  - PHY_ACK pulses exactly at cycle 19 after the strobe; oIsCable=0.
- iTRANSMIT=8'h06 with tx_ready=1: ordered set is 00111, 11000, 00111, 00110; oIsCable=1; PHY_ACK pulses once.
- Hard reset with tx_ready low for 3 cycles mid-preamble:
  - oSymbol stays unchanged during the stall;
  - no symbol is lost or duplicated; PHY_ACK pulses 3 cycles later than in the first scenario.
- tx_ready held low (TIMEOUT_CYCLES=255):
  - oTxFailed pulses after 255 stalled cycles and valid drops;
  - no PHY_ACK; busy clears after IFG_CYCLES.
- Second strobe while busy, plus a strobe with [2:0]=3'b000 while idle: both ignored; only one frame is emitted.
- Assert reset during ORDSET: next cycle oSymbol_valid=0, busy=0, no PHY_ACK; a fresh request afterwards transmits a full frame normally.
